cl_code_assigner: RTL and testbench

- Downstream neighbour of the code-length sequence extractor in the inflate core.
- After the extractor finishes writing the code-length buffer, this block reads the buffer twice:
  - pass 1: builds the length histogram;
  - then: computes the canonical first code per length (RFC 1951 3.2.2);
  - pass 2: emits one (symbol, length, code) record per non-zero-length symbol over a valid/ready stream to the Huffman decode-table writer.

---
 rtl/cl_code_assigner.sv | 202 ++++++++++++++++++++
 tb/tb_cl_code_assigner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_code_assigner.sv
// Canonical Huffman code assigner: histograms the code-length buffer, derives first codes per
// length, then streams (symbol, length, code) records. Optional Kraft check under CL_KRAFT_CHECK_EN.
module cl_code_assigner #(
  parameter int ADDR_W  = 9,
  parameter int MAX_LEN = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  sym_num,
  output logic               buff_ren,
  output logic [ADDR_W-1:0]  buff_raddr,
  input  logic [4:0]         buff_rdata,
  output logic [ADDR_W-1:0]  out_sym,
  output logic [3:0]         out_len,
  output logic [MAX_LEN-1:0] out_code,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CODE_W = MAX_LEN + 1;

  typedef enum logic [2:0] {IDLE, COUNT, NEXTCODE, ASSIGN, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   symNum_q, symNum_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   retAddr_q;
  logic                rdVld_q;
  logic [ADDR_W-1:0]   blCount_q [16];
  logic [ADDR_W-1:0]   blCount_d [16];
  logic [CODE_W-1:0]   nextCode_q [16];
  logic [CODE_W-1:0]   nextCode_d [16];
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   prevCount;
  logic [3:0]          bIdx_q, bIdx_d;
  logic                holdVld_q, holdVld_d;
  logic [ADDR_W-1:0]   holdSym_q, holdSym_d;
  logic [3:0]          holdLen_q, holdLen_d;
  logic [MAX_LEN-1:0]  holdCode_q, holdCode_d;
  logic [3:0]          inLen;
  logic                inLegal;
  logic                inRec;
  logic [MAX_LEN-1:0]  inCode;
  logic                rdEn;

  assign inLen   = buff_rdata[3:0];
  assign inLegal = rdVld_q && !buff_rdata[4] && (inLen != 4'd0);
  assign inRec   = inLegal && (state_q == ASSIGN);
  assign inCode  = nextCode_q[inLen][MAX_LEN-1:0];

  // A returning entry is presented straight away; it only lands in the hold register on a stall,
  // and a new read is issued only when the hold register will be free for its return.
  assign holdVld_d = (state_q == ASSIGN) && (holdVld_q || inRec) && !out_rdy;
  assign rdEn      = (addr_q < symNum_q) &&
                     ((state_q == COUNT) || ((state_q == ASSIGN) && !holdVld_d));

  assign buff_ren   = rdEn;
  assign buff_raddr = rdEn ? addr_q : '0;

  assign out_vld  = holdVld_q || inRec;
  assign out_sym  = holdVld_q ? holdSym_q  : (inRec ? retAddr_q : '0);
  assign out_len  = holdVld_q ? holdLen_q  : (inRec ? inLen     : '0);
  assign out_code = holdVld_q ? holdCode_q : (inRec ? inCode    : '0);

  assign busy = (state_q == COUNT) || (state_q == NEXTCODE) || (state_q == ASSIGN);
  assign done = (state_q == DONE);

  assign prevCount = (bIdx_q == 4'd1) ? '0 : CODE_W'(blCount_q[bIdx_q - 4'd1]);

  always_comb begin
    state_d    = state_q;
    symNum_d   = symNum_q;
    addr_d     = addr_q;
    blCount_d  = blCount_q;
    nextCode_d = nextCode_q;
    code_d     = code_q;
    bIdx_d     = bIdx_q;
    holdSym_d  = holdSym_q;
    holdLen_d  = holdLen_q;
    holdCode_d = holdCode_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          symNum_d = sym_num;
          addr_d   = '0;
          for (int i = 0; i < 16; i++) blCount_d[i] = '0;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (rdEn) addr_d = addr_q + ADDR_W'(1);
        if (inLegal) blCount_d[inLen] = blCount_q[inLen] + ADDR_W'(1);
        if (addr_q == symNum_q) begin
          state_d = NEXTCODE;
          bIdx_d  = 4'd1;
          code_d  = '0;
        end
      end
      NEXTCODE: begin
        code_d             = (code_q + prevCount) << 1;
        nextCode_d[bIdx_q] = code_d;
        bIdx_d             = bIdx_q + 4'd1;
        if (bIdx_q == 4'd15) begin
          state_d = ASSIGN;
          addr_d  = '0;
        end
      end
      ASSIGN: begin
        if (rdEn) addr_d = addr_q + ADDR_W'(1);
        if (inRec) begin
          nextCode_d[inLen] = nextCode_q[inLen] + CODE_W'(1);
          if (!out_rdy) begin
            holdSym_d  = retAddr_q;
            holdLen_d  = inLen;
            holdCode_d = inCode;
          end
        end
        if ((addr_q == symNum_q) && !holdVld_d) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      symNum_q   <= '0;
      addr_q     <= '0;
      retAddr_q  <= '0;
      rdVld_q    <= 1'b0;
      code_q     <= '0;
      bIdx_q     <= '0;
      holdVld_q  <= 1'b0;
      holdSym_q  <= '0;
      holdLen_q  <= '0;
      holdCode_q <= '0;
      for (int i = 0; i < 16; i++) begin
        blCount_q[i]  <= '0;
        nextCode_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      symNum_q   <= symNum_d;
      addr_q     <= addr_d;
      rdVld_q    <= rdEn;
      code_q     <= code_d;
      bIdx_q     <= bIdx_d;
      holdVld_q  <= holdVld_d;
      holdSym_q  <= holdSym_d;
      holdLen_q  <= holdLen_d;
      holdCode_q <= holdCode_d;
      if (rdEn) retAddr_q <= addr_q;
      blCount_q  <= blCount_d;
      nextCode_q <= nextCode_d;
    end
  end

`ifdef CL_KRAFT_CHECK_EN
  logic               errFlag_q, errFlag_d;
  logic signed [16:0] left_q, left_d, leftNext;

  // Remaining code space; going negative at any length means the tree is over-subscribed.
  assign leftNext = (left_q <<< 1) - $signed(17'(blCount_q[bIdx_q]));

  always_comb begin
    errFlag_d = errFlag_q;
    left_d    = left_q;
    case (state_q)
      IDLE: if (start) errFlag_d = 1'b0;
      COUNT: begin
        left_d = 17'sd1;
        if (rdVld_q && buff_rdata[4]) errFlag_d = 1'b1;
      end
      NEXTCODE: begin
        left_d = leftNext;
        if (leftNext[16]) errFlag_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errFlag_q <= 1'b0;
      left_q    <= 17'sd1;
    end else begin
      errFlag_q <= errFlag_d;
      left_q    <= left_d;
    end
  end

  assign err = errFlag_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cl_code_assigner.sv
// Bench for cl_code_assigner: directed table, hand sequences and randomized jobs checked
// against a closed-form canonical-code model.
module tb_cl_code_assigner;

  localparam int ADDR_W  = 9;
  localparam int MAX_LEN = 15;
`ifdef CL_KRAFT_CHECK_EN
  localparam bit KRAFT = 1'b1;
`else
  localparam bit KRAFT = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               start;
  logic [ADDR_W-1:0]  sym_num;
  logic               buff_ren;
  logic [ADDR_W-1:0]  buff_raddr;
  logic [4:0]         buff_rdata;
  logic [ADDR_W-1:0]  out_sym;
  logic [3:0]         out_len;
  logic [MAX_LEN-1:0] out_code;
  logic               out_vld;
  logic               out_rdy;
  logic               busy;
  logic               done;
  logic               err;

  typedef struct { int sym; int len; int code; } rec_t;

  typedef struct {
    int         n;
    logic [4:0] lens [8];
    int         mode;
    int         expLat;
    int         expRecs;
    bit         glitch;
    string      name;
  } vec_t;

  rec_t       expQ[$];
  rec_t       monRec;
  bit         codeCheck;
  int         curN;
  int         readCnt [512];
  logic [4:0] mem [512];
  int         errors = 0;
  int         checks = 0;
  int         recSeen = 0;
  vec_t       vecs [8];

  cl_code_assigner #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sym_num    (sym_num),
    .buff_ren   (buff_ren),
    .buff_raddr (buff_raddr),
    .buff_rdata (buff_rdata),
    .out_sym    (out_sym),
    .out_len    (out_len),
    .out_code   (out_code),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous code-length RAM.
  always @(posedge clk) if (buff_ren) buff_rdata <= mem[buff_raddr];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Code of a symbol = room taken by all shorter codes plus same-length symbols before it.
  task automatic buildModel(input int n, output bit cc, output bit expErr);
    int     bl [16];
    longint kraft;
    bit     illegal;
    int     l, l2, code;
    expQ.delete();
    illegal = 0;
    for (int i = 0; i < 16; i++) bl[i] = 0;
    for (int s = 0; s < n; s++) begin
      l = int'(mem[s]);
      if (l >= 16) illegal = 1;
      else if (l > 0) bl[l]++;
    end
    kraft = 0;
    for (int i = 1; i < 16; i++) kraft += longint'(bl[i]) * (longint'(1) << (15 - i));
    cc     = (kraft <= 32768);
    expErr = KRAFT && (illegal || kraft > 32768);
    for (int s = 0; s < n; s++) begin
      l = int'(mem[s]);
      if (l >= 1 && l <= 15) begin
        code = 0;
        for (int s2 = 0; s2 < n; s2++) begin
          l2 = int'(mem[s2]);
          if (l2 >= 1 && l2 <= 15) begin
            if (l2 < l) code += (1 << (l - l2));
            else if (l2 == l && s2 < s) code++;
          end
        end
        expQ.push_back('{s, l, code & 32'h7FFF});
      end
    end
  endtask

  logic               pStall;
  logic [ADDR_W-1:0]  pSym;
  logic [3:0]         pLen;
  logic [MAX_LEN-1:0] pCode;

  always @(negedge clk) begin
    if (rst) begin
      pStall = 1'b0;
    end else begin
      if (pStall)
        checkOutput("hold_stable", longint'(out_vld && out_sym == pSym && out_len == pLen && out_code == pCode), 1);
      if (buff_ren) begin
        checkOutput("raddr_in_range", longint'(int'(buff_raddr) < curN), 1);
        if (int'(buff_raddr) < curN) readCnt[buff_raddr]++;
      end
      if (out_vld && out_rdy) begin
        recSeen++;
        if (expQ.size() == 0) begin
          checkOutput("extra_record_sym", out_sym, -1);
        end else begin
          monRec = expQ.pop_front();
          checkOutput("rec_sym", out_sym, monRec.sym);
          checkOutput("rec_len", out_len, monRec.len);
          if (codeCheck) checkOutput("rec_code", out_code, monRec.code);
        end
      end
      pStall = out_vld && !out_rdy;
      pSym   = out_sym;
      pLen   = out_len;
      pCode  = out_code;
    end
  end

  // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random ready.
  task automatic applyStimulus(input int n, input int mode, input int expLat, input int expRecs,
                               input bit glitch, input string name);
    int cyc, base;
    bit cc, expErr;
    buildModel(n, cc, expErr);
    codeCheck = cc;
    for (int i = 0; i < 512; i++) readCnt[i] = 0;
    curN    = n;
    base    = recSeen;
    sym_num = ADDR_W'(n);
    start   = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    sym_num = '1;
    cyc     = 0;
    while (!done && cyc < 8 * n + 400) begin
      case (mode)
        1:       out_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = 1'b1;
      endcase
      if (glitch && cyc == 5) begin
        start   = 1'b1;
        sym_num = ADDR_W'(3);
      end
      @(posedge clk); #1;
      cyc++;
      start   = 1'b0;
      sym_num = '1;
    end
    checkOutput({name, "_done_seen"}, done, 1);
    if (expLat >= 0) checkOutput({name, "_latency"}, cyc, expLat);
    checkOutput({name, "_err"}, err, expErr);
    checkOutput({name, "_pending"}, expQ.size(), 0);
    if (expRecs >= 0) checkOutput({name, "_records"}, recSeen - base, expRecs);
    begin
      bit ok = 1'b1;
      for (int i = 0; i < n; i++) if (readCnt[i] != 2) ok = 1'b0;
      checkOutput({name, "_reads_twice"}, ok, 1);
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    checkOutput({name, "_idle_after"}, {done, busy}, 0);
    checkOutput({name, "_err_sticky"}, err, expErr);
  endtask

  task automatic loadVec(input int v);
    for (int i = 0; i < 512; i++) mem[i] = 5'd7;
    for (int i = 0; i < 8; i++) if (i < vecs[v].n) mem[i] = vecs[v].lens[i];
  endtask

  initial begin
    int cyc, base, n, maxL, mode;
    bit cc, expErr;

    vecs[0] = '{n: 8, lens: '{3,3,3,3,3,2,4,4}, mode: 0, expLat: 33, expRecs: 8, glitch: 0, name: "rfc"};
    vecs[1] = '{n: 5, lens: '{0,1,0,0,1,0,0,0}, mode: 0, expLat: 27, expRecs: 2, glitch: 0, name: "zeros"};
    vecs[2] = '{n: 8, lens: '{3,3,3,3,3,2,4,4}, mode: 1, expLat: -1, expRecs: 8, glitch: 0, name: "backpressure"};
    vecs[3] = '{n: 0, lens: '{0,0,0,0,0,0,0,0}, mode: 0, expLat: 17, expRecs: 0, glitch: 0, name: "empty"};
    vecs[4] = '{n: 1, lens: '{15,0,0,0,0,0,0,0}, mode: 0, expLat: 19, expRecs: 1, glitch: 0, name: "single15"};
    vecs[5] = '{n: 3, lens: '{1,1,1,0,0,0,0,0}, mode: 0, expLat: 23, expRecs: 3, glitch: 0, name: "oversub"};
    vecs[6] = '{n: 3, lens: '{20,1,1,0,0,0,0,0}, mode: 0, expLat: 23, expRecs: 2, glitch: 0, name: "illegal"};
    vecs[7] = '{n: 8, lens: '{3,3,3,3,3,2,4,4}, mode: 0, expLat: 33, expRecs: 8, glitch: 1, name: "start_busy"};

    for (int i = 0; i < 512; i++) mem[i] = 5'd7;
    rst     = 1'b1;
    start   = 1'b0;
    sym_num = '0;
    out_rdy = 1'b1;
    curN    = 0;
    codeCheck = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", {busy, done, err, out_vld, buff_ren}, 0);
    checkOutput("reset_raddr", buff_raddr, 0);
    checkOutput("reset_out", {out_sym, out_len, out_code}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      loadVec(v);
      applyStimulus(vecs[v].n, vecs[v].mode, vecs[v].expLat, vecs[v].expRecs, vecs[v].glitch, vecs[v].name);
    end

    for (int i = 0; i < 512; i++) mem[i] = (i < 316) ? 5'd8 : 5'd3;
    applyStimulus(316, 0, 649, 316, 1'b0, "full316");

    // Reset after the third record of a job, then the same job must run cleanly from address 0.
    loadVec(0);
    buildModel(8, cc, expErr);
    codeCheck = cc;
    curN    = 8;
    base    = recSeen;
    sym_num = ADDR_W'(8);
    start   = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while (recSeen < base + 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("rst_mid_third_record", recSeen - base, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
    checkOutput("rst_mid_outputs", {out_vld, busy, done}, 0);
    begin
      bit sawDone = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (done || busy || out_vld) sawDone = 1'b1;
      end
      checkOutput("rst_mid_quiet", sawDone, 0);
    end
    applyStimulus(8, 0, 33, 8, 1'b1, "after_rst");

    for (int j = 0; j < 12; j++) begin
      n    = $urandom_range(0, 40);
      maxL = $urandom_range(3, 15);
      for (int i = 0; i < 512; i++) mem[i] = 5'd7;
      for (int s = 0; s < n; s++)
        mem[s] = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, maxL));
      mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      applyStimulus(n, mode, (mode == 0) ? 2 * n + 17 : -1, -1, 1'b0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
